// File: rtl/uart_pkg.sv
// Shared types and default constants for the oversampling UART receiver.
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_oversample_if.sv
// Receive-side hand-off bundle: byte, strobes, busy flag and FSM state for observation.
interface uart_rx_oversample_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = UART_DATA_BITS
);

    // rx_valid/frame_err/parity_err are one-cycle strobes with no backpressure:
    // the consumer must sample them every cycle; rx_data is stable between rx_valid pulses.
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 frame_err;
    logic                 parity_err;
    logic                 busy;
    uart_rx_state_t       state;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, busy, state
    );

    modport slave (
        input rx_data, rx_valid, frame_err, parity_err, busy, state
    );

endinterface

// File: rtl/uart_rx_sync_vote.sv
// Line synchronizer plus tick-sampled history; votes over the last two samples and the live one.
module uart_rx_sync_vote (
    input  logic sysclk,
    input  logic reset,
    input  logic tick_16x,
    input  logic uart_rx,
    output logic sample,
    output logic prev_sample,
    output logic vote
);

    logic [1:0] sync;
    logic [1:0] hist;

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            hist <= 2'b11;
        end else begin
            sync <= {sync[0], uart_rx};
            if (tick_16x) begin
                hist <= {hist[0], sync[1]};
            end
        end
    end

    // The three-sample window is {hist, sync[1]}, so a vote is ready on the deciding tick itself.
    assign sample      = sync[1];
    assign prev_sample = hist[0];
    assign vote        = (hist[1] & hist[0]) | (hist[1] & sync[1]) | (hist[0] & sync[1]);

endmodule

// File: rtl/uart_rx_oversample.sv
// Oversampling UART receiver: start-glitch rejection, majority voting, framing check.
// Optional parity check compiled in with `define UART_RX_PARITY_EN.
module uart_rx_oversample
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 reset,
    input  logic                 tick_16x,
    input  logic                 uart_rx,
    uart_rx_oversample_if.master rx_if
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] DEC_CNT  = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_oversample
        $error("OVERSAMPLE must be even and at least 8");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    logic sample, prev_sample, vote;

    uart_rx_sync_vote u_sync_vote (
        .sysclk      (sysclk),
        .reset       (reset),
        .tick_16x    (tick_16x),
        .uart_rx     (uart_rx),
        .sample      (sample),
        .prev_sample (prev_sample),
        .vote        (vote)
    );

    uart_rx_state_t       state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [BW-1:0]        bitidx, bitidx_nxt;
    logic [DATA_BITS-1:0] shreg, shreg_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 valid_q, valid_nxt;
    logic                 ferr_q, ferr_nxt;
`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic                 par_bad, par_bad_nxt;
    logic                 perr_q, perr_nxt;
`endif

    wire decide = tick_16x && (cnt == DEC_CNT);

    always_ff @(posedge sysclk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bitidx  <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bitidx  <= bitidx_nxt;
            shreg   <= shreg_nxt;
            data_q  <= data_nxt;
            valid_q <= valid_nxt;
            ferr_q  <= ferr_nxt;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_nxt;
            perr_q  <= perr_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        bitidx_nxt = bitidx;
        shreg_nxt  = shreg;
        data_nxt   = data_q;
        valid_nxt  = 1'b0;
        ferr_nxt   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_nxt = par_bad;
        perr_nxt    = 1'b0;
`endif
        if (tick_16x && state != IDLE) begin
            cnt_nxt = (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        end
        case (state)
            IDLE: begin
                if (tick_16x && !sample && prev_sample) begin
                    cnt_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                // A start that does not hold low through mid-bit is treated as noise.
                if (decide) begin
                    if (!vote) begin
                        state_nxt  = DATA;
                        bitidx_nxt = '0;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (decide) begin
                    shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
                    if (bitidx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bitidx_nxt = bitidx + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (decide) begin
                    par_bad_nxt = (^shreg) ^ vote ^ PAR_SENSE;
                    state_nxt   = STOP;
                end
            end
`endif
            STOP: begin
                if (decide) begin
                    if (vote) begin
                        state_nxt = IDLE;
`ifdef UART_RX_PARITY_EN
                        if (par_bad) begin
                            perr_nxt = 1'b1;
                        end else begin
                            data_nxt  = shreg;
                            valid_nxt = 1'b1;
                        end
`else
                        data_nxt  = shreg;
                        valid_nxt = 1'b1;
`endif
                    end else begin
                        // Framing error outranks a parity mismatch on the same frame.
                        ferr_nxt  = 1'b1;
                        state_nxt = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                if (tick_16x && sample) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_if.parity_err = perr_q;
`else
    assign rx_if.parity_err = 1'b0;
`endif
    assign rx_if.busy  = (state != IDLE);
    assign rx_if.state = state;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Directed bench for uart_rx_oversample: frame table plus hand-built corner sequences.
module tb_uart_rx_oversample;
    import uart_pkg::*;

    localparam int TICK_DIV   = 10;
    localparam int BIT_TICKS  = 16;
    localparam logic PAR_ODD  = 1'b0;

    logic sysclk = 1'b0;
    logic reset  = 1'b0;
    logic tick_16x = 1'b0;
    logic uart_rx  = 1'b1;

    uart_rx_oversample_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_oversample #(
        .OVERSAMPLE (16),
        .DATA_BITS  (8),
        .PARITY_ODD (0)
    ) dut (
        .sysclk   (sysclk),
        .reset    (reset),
        .tick_16x (tick_16x),
        .uart_rx  (uart_rx),
        .rx_if    (rx_if)
    );

    // ---------------- clock / tick / watchdog ----------------
    always #5 sysclk = ~sysclk;

    int div = 0;
    always @(negedge sysclk) begin
        div = (div == TICK_DIV - 1) ? 0 : div + 1;
        tick_16x = (div == 0);
    end

    initial begin
        repeat (90000) @(posedge sysclk);
        $display("FAIL watchdog: simulation ran past 90000 cycles, expected to finish earlier");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int valid_cnt = 0;
    int ferr_cnt  = 0;
    int perr_cnt  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge sysclk) begin
        if (reset) begin
            if (rx_if.rx_valid) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got rx_data 0x%0h, expected no strobe", rx_if.rx_data);
                end else begin
                    check("sb_rx_data", rx_if.rx_data, exp_q.pop_front());
                end
            end
            if (rx_if.frame_err)  ferr_cnt++;
            if (rx_if.parity_err) perr_cnt++;
            if (rx_if.rx_valid || rx_if.frame_err || rx_if.parity_err)
                check("strobe_onehot", $countones({rx_if.rx_valid, rx_if.frame_err, rx_if.parity_err}), 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge sysclk);
            while (!tick_16x) @(posedge sysclk);
        end
    endtask

    task automatic send_bit(input logic v, input int nt);
        uart_rx = v;
        wait_ticks(nt);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_v, input int stop_ticks);
        send_bit(1'b0, BIT_TICKS);
        for (int i = 0; i < 8; i++) send_bit(d[i], BIT_TICKS);
`ifdef UART_RX_PARITY_EN
        send_bit((^d) ^ PAR_ODD ^ par_flip, BIT_TICKS);
`else
        if (par_flip) $display("note: parity flip ignored without parity build");
`endif
        send_bit(stop_v, stop_ticks);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_v;
        int         n_valid;
        int         n_ferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    // ---------------- test sequence ----------------
    initial begin
        int v0, f0, p0;

        vecs[0] = '{8'hA5, 1'b1, 1, 0, 8'hA5};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 8'h00};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 8'hFF};
        vecs[3] = '{8'h3C, 1'b1, 1, 0, 8'h3C};
        vecs[4] = '{8'h81, 1'b0, 0, 1, 8'h3C};
        vecs[5] = '{8'h5A, 1'b1, 1, 0, 8'h5A};

        repeat (3) @(posedge sysclk);
        @(negedge sysclk);
        check("reset_rx_data",    rx_if.rx_data,    0);
        check("reset_rx_valid",   rx_if.rx_valid,   0);
        check("reset_frame_err",  rx_if.frame_err,  0);
        check("reset_parity_err", rx_if.parity_err, 0);
        check("reset_busy",       rx_if.busy,       0);
        check("reset_state",      rx_if.state,      IDLE);
        reset = 1'b1;
        wait_ticks(4);

        // Table of whole frames, one idle bit after each.
        foreach (vecs[k]) begin
            v0 = valid_cnt;
            f0 = ferr_cnt;
            if (vecs[k].n_valid != 0) exp_q.push_back(vecs[k].data);
            send_frame(vecs[k].data, 1'b0, vecs[k].stop_v, BIT_TICKS);
            send_bit(1'b1, BIT_TICKS);
            @(negedge sysclk);
            check("vec_valid_count", valid_cnt - v0, vecs[k].n_valid);
            check("vec_ferr_count",  ferr_cnt - f0,  vecs[k].n_ferr);
            check("vec_rx_data",     rx_if.rx_data,  vecs[k].exp_data);
            check("vec_busy",        rx_if.busy,     0);
        end

        // Start glitch: 4 ticks low, then a valid 0x3C.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, 4);
        send_bit(1'b1, 8);
        @(negedge sysclk);
        check("glitch_state", rx_if.state, IDLE);
        check("glitch_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        send_bit(1'b1, BIT_TICKS);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b0, 1'b1, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("glitch_next_valid", valid_cnt - v0, 1);
        check("glitch_next_data",  rx_if.rx_data, 8'h3C);

        // One-tick high spike exactly on the deciding tick of data bit 3 of 0x00.
        v0 = valid_cnt;
        exp_q.push_back(8'h00);
        send_bit(1'b0, BIT_TICKS);
        send_bit(1'b0, 3 * BIT_TICKS);
        send_bit(1'b0, 9);
        send_bit(1'b1, 1);
        send_bit(1'b0, 6);
        send_bit(1'b0, 4 * BIT_TICKS);
        send_bit(1'b1, 2 * BIT_TICKS);
        @(negedge sysclk);
        check("spike_valid", valid_cnt - v0, 1);
        check("spike_data",  rx_if.rx_data, 8'h00);

        // Stop held low for 20 bit times: one frame error, wait for line high.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 10 * BIT_TICKS);
        @(negedge sysclk);
        check("break_state_mid", rx_if.state, WAIT_HIGH);
        check("break_busy_mid",  rx_if.busy, 1);
        send_bit(1'b0, 10 * BIT_TICKS);
        @(negedge sysclk);
        check("break_state_late", rx_if.state, WAIT_HIGH);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("break_ferr",  ferr_cnt - f0, 1);
        check("break_valid", valid_cnt - v0, 0);
        check("break_data",  rx_if.rx_data, 8'h00);
        check("break_idle",  rx_if.state, IDLE);

        // Back-to-back frames with exactly one stop bit.
        v0 = valid_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_frame(8'h55, 1'b0, 1'b1, BIT_TICKS);
        send_frame(8'hAA, 1'b0, 1'b1, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("b2b_valid", valid_cnt - v0, 2);
        check("b2b_data",  rx_if.rx_data, 8'hAA);

        // Reset in the middle of data bits, then a clean 0x12.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        send_bit(1'b0, BIT_TICKS);
        send_bit(1'b1, 8);
        #2 reset = 1'b0;
        @(negedge sysclk);
        check("mid_reset_busy", rx_if.busy, 0);
        check("mid_reset_data", rx_if.rx_data, 0);
        uart_rx = 1'b1;
        repeat (5) @(posedge sysclk);
        #2 reset = 1'b1;
        wait_ticks(20);
        @(negedge sysclk);
        check("post_reset_state", rx_if.state, IDLE);
        check("post_reset_no_strobe", (valid_cnt - v0) + (ferr_cnt - f0), 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b0, 1'b1, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("post_reset_valid", valid_cnt - v0, 1);
        check("post_reset_data",  rx_if.rx_data, 8'h12);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 needs parity bit 1; sending 0 must flag an error.
        v0 = valid_cnt;
        p0 = perr_cnt;
        send_frame(8'h07, 1'b1, 1'b1, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("par_bad_perr",  perr_cnt - p0, 1);
        check("par_bad_valid", valid_cnt - v0, 0);
        check("par_bad_data",  rx_if.rx_data, 8'h12);
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b0, 1'b1, BIT_TICKS);
        send_bit(1'b1, BIT_TICKS);
        @(negedge sysclk);
        check("par_good_perr",  perr_cnt - p0, 1);
        check("par_good_valid", valid_cnt - v0, 1);
        check("par_good_data",  rx_if.rx_data, 8'h07);
`else
        p0 = perr_cnt;
        check("no_parity_err", p0, 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
